// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared types and constants for the FSM sequence checker
// Contents: controller state enum, length of the x=0 forcing phase, and the
//           FSM state that the forcing phase must reach.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of cycles x is held low before the pattern starts.
  localparam int SYNC_CYCLES = 3;

  // {y1,y2} every start state converges to under x=0.
  localparam logic [1:0] SYNC_STATE = 2'b01;

endpackage

// File: rtl/fsm_seq_checker_if.sv
// rtl/fsm_seq_checker_if.sv - host/FSM-side signal bundle of the sequence checker
// Parameters: LEN (max pattern bits), CNT_W (error counter width).
// Signals: start, len, pattern, expect_z1, expect_z2 (host requests);
//          fsm_x (to FSM); fsm_z1, fsm_z2, fsm_y1, fsm_y2 (from FSM);
//          busy, done, pass, err_count, first_err_idx (results);
//          sync_err only when SEQ_SYNC_CHECK_EN is defined.
// Modports: master = host/bench side, slave = checker side.
interface fsm_seq_checker_if #(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(LEN + 1);
  localparam int IDX_W = $clog2(LEN);

  logic             start;
  logic [LEN_W-1:0] len;
  logic [LEN-1:0]   pattern;
  logic [LEN-1:0]   expect_z1;
  logic [LEN-1:0]   expect_z2;
  logic             fsm_x;
  logic             fsm_z1;
  logic             fsm_z2;
  logic             fsm_y1;
  logic             fsm_y2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [IDX_W-1:0] first_err_idx;
`ifdef SEQ_SYNC_CHECK_EN
  logic             sync_err;
`endif

  modport master (
    output start, len, pattern, expect_z1, expect_z2,
    output fsm_z1, fsm_z2, fsm_y1, fsm_y2,
    input  fsm_x, busy, done, pass, err_count, first_err_idx
`ifdef SEQ_SYNC_CHECK_EN
    , input sync_err
`endif
  );

  modport slave (
    input  start, len, pattern, expect_z1, expect_z2,
    input  fsm_z1, fsm_z2, fsm_y1, fsm_y2,
    output fsm_x, busy, done, pass, err_count, first_err_idx
`ifdef SEQ_SYNC_CHECK_EN
    , output sync_err
`endif
  );

endinterface

// File: rtl/fsm_seq_checker.sv
// rtl/fsm_seq_checker.sv - drives a latched x pattern into the 2-bit FSM and checks z1/z2
// Ports: clk (rising edge, shared with the FSM), rst_n (async active-low),
//        bus (fsm_seq_checker_if.slave: request, FSM hookup and results).
// Optional macro SEQ_SYNC_CHECK_EN: check {y1,y2}==01 at the end of the forcing
//        phase and report sync_err; without it the state bits are ignored.
module fsm_seq_checker
  import fsm_seq_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  fsm_seq_checker_if.slave bus
);

  localparam int LEN_W = $clog2(LEN + 1);
  localparam int IDX_W = $clog2(LEN);

  state_t           state, state_n;
  logic             x_q, x_n;
  logic [1:0]       sync_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [LEN_W-1:0] len_q;
  logic [LEN-1:0]   pat_q, ez1_q, ez2_q;
  logic [CNT_W-1:0] err_q, err_n;
  logic [IDX_W-1:0] first_q;
  logic             pass_q;

  logic             accept;
  logic             sync_last;
  logic             sync_bad;
  logic             run_last;
  logic             bit_fail;
  logic [LEN_W-1:0] len_clamp;
  logic [IDX_W-1:0] idx_next;

  assign accept    = (state == IDLE) && bus.start;
  assign sync_last = (state == SYNC) && (sync_cnt == 2'(SYNC_CYCLES - 1));
  assign run_last  = (LEN_W'(bit_idx) == (len_q - LEN_W'(1)));
  assign len_clamp = (bus.len > LEN_W'(LEN)) ? LEN_W'(LEN) : bus.len;
  assign idx_next  = bit_idx + IDX_W'(1);

  // z1/z2 belong to the cycle whose x we drove; they are sampled at its closing edge.
  assign bit_fail = (state == RUN) &&
                    ((bus.fsm_z1 != ez1_q[bit_idx]) || (bus.fsm_z2 != ez2_q[bit_idx]));

  always_comb begin
    err_n = err_q;
    if (bit_fail && (err_q != {CNT_W{1'b1}})) begin
      err_n = err_q + CNT_W'(1);
    end
  end

`ifdef SEQ_SYNC_CHECK_EN
  logic sync_err_q;

  assign sync_bad = ({bus.fsm_y1, bus.fsm_y2} != SYNC_STATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_q <= 1'b0;
    end else if (accept) begin
      sync_err_q <= 1'b0;
    end else if (sync_last && sync_bad) begin
      sync_err_q <= 1'b1;
    end
  end

  assign bus.sync_err = sync_err_q;
`else
  logic unused_state_bits;

  assign unused_state_bits = bus.fsm_y1 ^ bus.fsm_y2;
  assign sync_bad          = 1'b0;
`endif

  // Next state and next x; x is registered so the FSM sees a clean edge-aligned input.
  always_comb begin
    state_n = state;
    x_n     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = SYNC;
      end
      SYNC: begin
        if (sync_last) begin
          if ((len_q != '0) && !sync_bad) begin
            state_n = RUN;
            x_n     = pat_q[0];
          end else begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (run_last) begin
          state_n = DONE;
        end else begin
          x_n = pat_q[idx_next];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_q   <= 1'b0;
    end else begin
      state <= state_n;
      x_q   <= x_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_cnt <= '0;
      bit_idx  <= '0;
      len_q    <= '0;
      pat_q    <= '0;
      ez1_q    <= '0;
      ez2_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      if (accept) begin
        sync_cnt <= '0;
        bit_idx  <= '0;
        len_q    <= len_clamp;
        pat_q    <= bus.pattern;
        ez1_q    <= bus.expect_z1;
        ez2_q    <= bus.expect_z2;
        err_q    <= '0;
        first_q  <= '0;
      end
      if (state == SYNC) begin
        sync_cnt <= sync_cnt + 2'd1;
      end
      if (state == RUN) begin
        bit_idx <= idx_next;
        err_q   <= err_n;
        if (bit_fail && (err_q == '0)) begin
          first_q <= bit_idx;
        end
      end
      // pass is settled on entry to DONE so it is valid alongside the done pulse,
      // and err_n already folds in the final bit's comparison.
      if ((state != DONE) && (state_n == DONE)) begin
        pass_q <= (err_n == '0) && !(sync_last && sync_bad);
      end
    end
  end

  assign bus.fsm_x         = x_q;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule
